// File: rtl/right_shift_unit.sv
// right_shift_unit
//
// Multi-cycle logical/arithmetic right shifter (SRL/SRA). Each step moves the
// working word right by half the width while at least that many positions
// remain, and by one position otherwise, so only two fixed shift paths exist.
// A start/done handshake lets the control unit stall while a shift runs.
//
// Ports:
//   Clk    in   1        clock, rising edge
//   Rst    in   1        asynchronous active-high reset
//   Start  in   1        shift request, sampled only in IDLE
//   In     in   WIDTH    operand, captured when Start is accepted
//   Shamt  in   SHAMT_W  shift amount 0..WIDTH-1, captured with In
//   Arith  in   1        0 = zero fill, 1 = sign fill from In[WIDTH-1]
//   Out    out  WIDTH    result register, holds until the next completion
//   Busy   out  1        high while shifting
//   Done   out  1        one-cycle completion pulse; Out valid from here on
//
// Only WIDTH = 32 with SHAMT_W = 5 is supported.

module right_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [WIDTH-1:0]   In,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic               Arith,
    output logic [WIDTH-1:0]   Out,
    output logic               Busy,
    output logic               Done
);

    localparam int                 HALF_W = WIDTH / 2;
    localparam logic [SHAMT_W-1:0] STEP_BIG = SHAMT_W'(HALF_W);
    localparam logic [SHAMT_W-1:0] STEP_ONE = SHAMT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   w, w_next;
    logic [SHAMT_W-1:0] r, r_next;
    logic               f, f_next;
    logic [WIDTH-1:0]   out_next;

    // Coarse path: drop the low half, fill the top half with the fill bit.
    function automatic logic [WIDTH-1:0] shift_big(input logic [WIDTH-1:0] word,
                                                   input logic fill);
        return {{HALF_W{fill}}, word[WIDTH-1:HALF_W]};
    endfunction

    // Fine path: single-position shift with the fill bit entering at the top.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] word,
                                                   input logic fill);
        return {fill, word[WIDTH-1:1]};
    endfunction

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            w     <= '0;
            r     <= '0;
            f     <= 1'b0;
            Out   <= '0;
        end else begin
            state <= state_next;
            w     <= w_next;
            r     <= r_next;
            f     <= f_next;
            Out   <= out_next;
        end
    end

    always_comb begin
        state_next = state;
        w_next     = w;
        r_next     = r;
        f_next     = f;
        out_next   = Out;
        Busy       = 1'b0;
        Done       = 1'b0;

        case (state)
            IDLE: begin
                if (Start) begin
                    w_next     = In;
                    r_next     = Shamt;
                    // Logical shifts always fill with zero regardless of sign.
                    f_next     = Arith & In[WIDTH-1];
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                Busy = 1'b1;
                if (r >= STEP_BIG) begin
                    w_next = shift_big(w, f);
                    r_next = r - STEP_BIG;
                end else if (r != '0) begin
                    w_next = shift_one(w, f);
                    r_next = r - STEP_ONE;
                end else begin
                    out_next   = w;
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_right_shift_unit.sv
module tb_right_shift_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [31:0] In;
    logic [4:0]  Shamt;
    logic        Arith;
    logic [31:0] Out;
    logic        Busy;
    logic        Done;

    int total = 0;
    int bad   = 0;

    // Model of the Out register contents between completions.
    logic [31:0] last_out;

    // Observations from the most recent launch.
    int          obs_done_j;
    int          obs_busy_n;
    int          obs_done_n;
    bit          obs_overlap;
    bit          obs_early;
    bit          obs_low_after;
    logic [31:0] obs_out;

    right_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .In    (In),
        .Shamt (Shamt),
        .Arith (Arith),
        .Out   (Out),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    // Reference: plain language-level shift operators.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input int sh,
                                               input logic ar);
        logic signed [31:0] s;
        logic [31:0]        res;
        s = a;
        if (ar) res = s >>> sh;
        else    res = a >> sh;
        return res;
    endfunction

    // Number of shift steps from the shift amount.
    function automatic int ref_steps(input int sh);
        return (sh >= 16 ? 1 : 0) + (sh % 16);
    endfunction

    // Launch one request and observe until the cycle after Done. Observation j
    // is taken at the falling edge after rising edge k+j (k = accept edge), so
    // it is the value that edge k+j+1 samples. Optionally re-pulses Start at
    // observation inj_j with a different operand. Returns at a falling edge
    // with Start low; the next launch may be driven immediately.
    task automatic launch(input logic [31:0] a, input logic [4:0] sh, input logic ar,
                          input int inj_j, input logic [31:0] a2, input logic [4:0] sh2);
        bit seen;
        obs_done_j = -1; obs_busy_n = 0; obs_done_n = 0;
        obs_overlap = 0; obs_early = 0; obs_low_after = 0; obs_out = 'x;
        seen = 0;
        Start = 1'b1; In = a; Shamt = sh; Arith = ar;
        @(posedge Clk);
        for (int j = 0; j < 40; j++) begin
            @(negedge Clk);
            if (j == 0) begin
                Start = 1'b0; In = $urandom; Shamt = 5'($urandom); Arith = 1'($urandom);
            end
            if (j == inj_j) begin
                Start = 1'b1; In = a2; Shamt = sh2;
            end
            if (inj_j >= 0 && j == inj_j + 1) Start = 1'b0;
            if (Busy) obs_busy_n++;
            if (Busy && Done) obs_overlap = 1;
            if (Done) begin
                obs_done_n++;
                if (!seen) begin
                    seen = 1; obs_done_j = j; obs_out = Out;
                end
            end else if (!seen && Out !== last_out) begin
                obs_early = 1;
            end
            if (seen && j == obs_done_j + 1) begin
                obs_low_after = !Done;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; In = '0; Shamt = '0; Arith = 1'b0;
        #2;
        total++;
        if (Out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h want=%h", Out, 32'h0); end
        total++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            bad++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", Busy, Done);
        end
        @(negedge Clk); @(negedge Clk);
        Rst = 1'b0;
        last_out = 32'h0;
    endtask

    task automatic test_shift16();
        launch(32'h12345678, 5'd16, 1'b0, -1, '0, '0);
        total++;
        if (obs_out !== 32'h00001234) begin bad++; $display("FAIL srl16_out got=%h want=%h", obs_out, 32'h00001234); end
        total++;
        if (obs_done_j !== 2) begin bad++; $display("FAIL srl16_latency got=%0d want=%0d", obs_done_j + 1, 3); end
        total++;
        if (obs_busy_n !== 2) begin bad++; $display("FAIL srl16_busy got=%0d want=%0d", obs_busy_n, 2); end
        total++;
        if (obs_done_n !== 1 || obs_overlap || obs_early || !obs_low_after) begin
            bad++;
            $display("FAIL srl16_protocol got pulses=%0d overlap=%0d early=%0d fell=%0d want 1 0 0 1",
                     obs_done_n, obs_overlap, obs_early, obs_low_after);
        end
        last_out = 32'h00001234;
    endtask

    task automatic test_arith_and_extremes();
        logic [31:0] a_t   [5] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'hDEADBEEF};
        logic [4:0]  sh_t  [5] = '{5'd4, 5'd4, 5'd31, 5'd31, 5'd0};
        logic        ar_t  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_t [5] = '{32'hF8000000, 32'h08000000, 32'h00000001, 32'hFFFFFFFF, 32'hDEADBEEF};
        int          lat_t [5] = '{6, 6, 18, 18, 2};
        for (int i = 0; i < 5; i++) begin
            launch(a_t[i], sh_t[i], ar_t[i], -1, '0, '0);
            total++;
            if (obs_out !== exp_t[i]) begin
                bad++; $display("FAIL fixed%0d_out got=%h want=%h", i, obs_out, exp_t[i]);
            end
            total++;
            if (obs_done_j + 1 !== lat_t[i]) begin
                bad++; $display("FAIL fixed%0d_latency got=%0d want=%0d", i, obs_done_j + 1, lat_t[i]);
            end
            total++;
            if (obs_busy_n !== lat_t[i] - 1 || obs_overlap || obs_early || !obs_low_after) begin
                bad++;
                $display("FAIL fixed%0d_protocol got busy=%0d overlap=%0d early=%0d fell=%0d want busy=%0d 0 0 1",
                         i, obs_busy_n, obs_overlap, obs_early, obs_low_after, lat_t[i] - 1);
            end
            last_out = exp_t[i];
        end
    endtask

    task automatic test_start_while_busy();
        int extra;
        // Second request arrives on edge k+3 (observation 2).
        launch(32'hFF000000, 5'd8, 1'b0, 2, 32'h00000001, 5'd1);
        total++;
        if (obs_out !== 32'h00FF0000) begin bad++; $display("FAIL busystart_out got=%h want=%h", obs_out, 32'h00FF0000); end
        total++;
        if (obs_done_j + 1 !== 10) begin bad++; $display("FAIL busystart_latency got=%0d want=%0d", obs_done_j + 1, 10); end
        last_out = 32'h00FF0000;
        extra = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge Clk);
            if (Done || Busy) extra++;
        end
        total++;
        if (obs_done_n + extra !== 1 || Out !== 32'h00FF0000) begin
            bad++;
            $display("FAIL busystart_single got pulses=%0d extra_activity=%0d out=%h want 1 0 %h",
                     obs_done_n, extra, Out, 32'h00FF0000);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        launch(32'h000000AA, 5'd1, 1'b0, -1, '0, '0);
        total++;
        if (obs_out !== 32'h00000055) begin bad++; $display("FAIL prior_out got=%h want=%h", obs_out, 32'h00000055); end
        last_out = 32'h00000055;
        Start = 1'b1; In = 32'hAAAAAAAA; Shamt = 5'd20; Arith = 1'b0;
        @(posedge Clk);
        @(negedge Clk); Start = 1'b0;
        @(negedge Clk); @(negedge Clk);
        #1 Rst = 1'b1;
        #1;
        total++;
        if (Out !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
            bad++; $display("FAIL midreset_async got out=%h busy=%b done=%b want 0 0 0", Out, Busy, Done);
        end
        @(negedge Clk);
        Rst = 1'b0;
        last_out = 32'h0;
        stray = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge Clk);
            if (Done || Busy || Out !== 32'h0) stray++;
        end
        total++;
        if (stray !== 0) begin bad++; $display("FAIL midreset_abandon got=%0d active cycles want=0", stray); end
        launch(32'h00000002, 5'd1, 1'b0, -1, '0, '0);
        total++;
        if (obs_out !== 32'h1 || obs_done_j + 1 !== 3) begin
            bad++; $display("FAIL postreset_op got out=%h lat=%0d want %h 3", obs_out, obs_done_j + 1, 32'h1);
        end
        last_out = 32'h1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_t [2] = '{32'hCAFEF00D, 32'h87654321};
        logic [4:0]  s_t [2] = '{5'd17, 5'd3};
        logic        r_t [2] = '{1'b1, 1'b1};
        logic [31:0] exp;
        // launch returns on the observation where Done has just fallen, so the
        // next Start is sampled on that same edge.
        for (int i = 0; i < 2; i++) begin
            launch(a_t[i], s_t[i], r_t[i], -1, '0, '0);
            exp = ref_result(a_t[i], int'(s_t[i]), r_t[i]);
            total++;
            if (obs_out !== exp || obs_done_j !== ref_steps(int'(s_t[i])) + 1) begin
                bad++;
                $display("FAIL b2b%0d got out=%h lat=%0d want %h %0d", i, obs_out, obs_done_j + 1,
                         exp, ref_steps(int'(s_t[i])) + 2);
            end
            last_out = exp;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, exp;
        logic [4:0]  sh;
        logic        ar;
        int          steps;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; sh = 5'($urandom); ar = 1'($urandom);
            if (i % 4 == 0) a[31] = 1'b1;
            launch(a, sh, ar, -1, '0, '0);
            exp = ref_result(a, int'(sh), ar);
            steps = ref_steps(int'(sh));
            total++;
            if (obs_out !== exp || obs_done_j !== steps + 1 || obs_busy_n !== steps + 1 ||
                obs_overlap || obs_early || !obs_low_after || obs_done_n !== 1) begin
                bad++;
                $display("FAIL rand%0d in=%h sh=%0d ar=%0d got out=%h lat=%0d busy=%0d want out=%h lat=%0d busy=%0d",
                         i, a, sh, ar, obs_out, obs_done_j + 1, obs_busy_n, exp, steps + 2, steps + 1);
            end
            last_out = exp;
        end
    endtask

    initial begin
        test_reset();
        test_shift16();
        test_arith_and_extremes();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
